// File: rtl/io_mailbox_pkg.sv
// io_mailbox_pkg: shared definitions for the io_mailbox peripheral.
//   - register offsets within the 4-word window (address[1:0])
//   - STATUS and CTRL bit positions
//   - lane_mask(): builds a byte-lane masked write word
package io_mailbox_pkg;

  typedef enum logic [1:0] {
    RegData   = 2'd0,
    RegStatus = 2'd1,
    RegCtrl   = 2'd2,
    RegCount  = 2'd3
  } reg_off_e;

  // STATUS bit positions
  localparam int unsigned StRxNonempty = 0;
  localparam int unsigned StRxFull     = 1;
  localparam int unsigned StTxEmpty    = 2;
  localparam int unsigned StTxFull     = 3;
  localparam int unsigned StTxOverflow = 4;

  // CTRL bit positions
  localparam int unsigned CtrlRxIrqEn = 0;
  localparam int unsigned CtrlTxIrqEn = 1;

  // Unselected byte lanes are written as 8'h00.
  function automatic logic [15:0] lane_mask(input logic [15:0] d, input logic hi, input logic lo);
    return {(hi ? d[15:8] : 8'h00), (lo ? d[7:0] : 8'h00)};
  endfunction

endpackage

// File: rtl/io_fifo.sv
// io_fifo: synchronous FIFO with combinational head output.
// Ports:
//   clock, reset    rising-edge clock, synchronous active-high reset
//   push, wdata     write request / data (ignored while full)
//   pop             read request (ignored while empty)
//   rdata           current head entry
//   full, empty     occupancy flags derived from the registered count
//   count           number of stored entries (clog2(DEPTH)+1 bits)
// Simultaneous push and pop both take effect; the count is then unchanged.
module io_fifo
  import io_mailbox_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 16
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wptr_q, wptr_d;
  logic [PtrW-1:0]  rptr_q, rptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == CntW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rdata   = mem_q[rptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // DEPTH is a power of two, so pointer overflow wraps modulo DEPTH.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q + CntW'(do_push) - CntW'(do_pop);
    if (do_push) wptr_d = wptr_q + PtrW'(1);
    if (do_pop)  rptr_d = rptr_q + PtrW'(1);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset; only entries behind valid pointers are ever read.
  always_ff @(posedge clock) begin
    if (do_push) mem_q[wptr_q] <= wdata;
  end

endmodule

// File: rtl/io_mailbox.sv
// io_mailbox: memory-mapped mailbox responding on the CPU external bus.
// Register window (4 words at BASE_ADDR in device space):
//   0 DATA   read = RX head (pops), write = TX push
//   1 STATUS rx_nonempty, rx_full, tx_empty, tx_full, tx_overflow (W1C)
//   2 CTRL   rx_irq_en, tx_irq_en
//   3 COUNT  [7:0] rx count, [15:8] tx count
// Ports:
//   clock, reset             system clock, synchronous active-high reset
//   address, data            CPU word address, bidirectional data bus
//   memNotRead, memNotWrite  active-low strobes
//   csh_n, csl_n             active-low byte-lane selects
//   select_dev               1 = device space
//   rx_data/rx_valid/rx_ready  inbound stream into the RX FIFO
//   tx_data/tx_valid/tx_ready  outbound stream from the TX FIFO
//   irq                      interrupt request
// Build option: define IO_MAILBOX_IRQ_EN to implement CTRL and the registered irq;
// otherwise CTRL reads 0 and irq is tied low.
module io_mailbox
  import io_mailbox_pkg::*;
#(
  parameter logic [14:0] BASE_ADDR  = 15'h7FF0,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [14:0] address,
  inout  wire  [15:0] data,
  input  logic        memNotRead,
  input  logic        memNotWrite,
  input  logic        csh_n,
  input  logic        csl_n,
  input  logic        select_dev,
  input  logic [15:0] rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [15:0] tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        irq
);

  localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;

  // FIFO interfaces
  logic [15:0]     rx_head;
  logic            rx_full, rx_empty, rx_push, rx_pop;
  logic [CntW-1:0] rx_cnt;
  logic            tx_full, tx_empty, tx_push, tx_pop;
  logic [CntW-1:0] tx_cnt;
  logic [15:0]     wr_word;

  // Bus cycle tracking
  logic        rd_prev_q, rd_prev_d, wr_prev_q, wr_prev_d;
  logic        hold_q, hold_d;
  logic        rd_armed_q, rd_armed_d, wr_armed_q, wr_armed_d;
  logic        rd_commit_q, rd_commit_d, wr_commit_q, wr_commit_d;
  reg_off_e    rd_off_q, rd_off_d, wr_off_q, wr_off_d;
  logic [15:0] wr_data_q, wr_data_d;
  logic [1:0]  wr_lanes_q, wr_lanes_d;  // {high, low}, 1 = selected
  logic        ovf_q, ovf_d;

  logic        sel, rd_fall, wr_fall, rd_drive;
  reg_off_e    cur_off;
  logic [15:0] rd_word, ctrl_rd;

  assign sel     = select_dev && (address[14:2] == BASE_ADDR[14:2]) && !(csh_n && csl_n);
  assign cur_off = reg_off_e'(address[1:0]);
  // Overlapping strobes count as a write, so a read only arms with the write strobe high.
  assign wr_fall = wr_prev_q && !memNotWrite && sel && !hold_q;
  assign rd_fall = rd_prev_q && !memNotRead && memNotWrite && sel && !hold_q;

  always_comb begin
    rd_prev_d   = memNotRead;
    wr_prev_d   = memNotWrite;
    // A strobe already low at reset release must go high before any cycle can arm.
    hold_d      = hold_q && !(memNotRead && memNotWrite);
    rd_armed_d  = rd_armed_q;
    wr_armed_d  = wr_armed_q;
    rd_off_d    = rd_off_q;
    wr_off_d    = wr_off_q;
    wr_data_d   = wr_data_q;
    wr_lanes_d  = wr_lanes_q;
    rd_commit_d = 1'b0;
    wr_commit_d = 1'b0;

    if (wr_fall) begin
      wr_armed_d = 1'b1;
      rd_armed_d = 1'b0;
      wr_off_d   = cur_off;
    end else if (rd_fall) begin
      rd_armed_d = 1'b1;
      rd_off_d   = cur_off;
    end

    if (!memNotWrite && (wr_armed_q || wr_fall)) begin
      wr_data_d  = data;
      wr_lanes_d = {!csh_n, !csl_n};
    end

    if (rd_armed_q && memNotRead) begin
      rd_armed_d  = 1'b0;
      rd_commit_d = 1'b1;
    end
    if (wr_armed_q && memNotWrite) begin
      wr_armed_d  = 1'b0;
      wr_commit_d = 1'b1;
    end
  end

  // Commit actions, one clock after the sampled rising strobe edge.
  assign wr_word = lane_mask(wr_data_q, wr_lanes_q[1], wr_lanes_q[0]);
  assign rx_pop  = rd_commit_q && (rd_off_q == RegData) && !rx_empty;
  assign tx_push = wr_commit_q && (wr_off_q == RegData) && !tx_full;
  assign rx_push = rx_valid && !rx_full;
  assign tx_pop  = tx_ready && !tx_empty;

  always_comb begin
    ovf_d = ovf_q;
    if (wr_commit_q && (wr_off_q == RegData) && tx_full) begin
      ovf_d = 1'b1;
    end else if (wr_commit_q && (wr_off_q == RegStatus) && wr_lanes_q[0]
                 && wr_data_q[StTxOverflow]) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rd_prev_q   <= 1'b1;
      wr_prev_q   <= 1'b1;
      hold_q      <= !(memNotRead && memNotWrite);
      rd_armed_q  <= 1'b0;
      wr_armed_q  <= 1'b0;
      rd_commit_q <= 1'b0;
      wr_commit_q <= 1'b0;
      rd_off_q    <= RegData;
      wr_off_q    <= RegData;
      wr_data_q   <= '0;
      wr_lanes_q  <= '0;
      ovf_q       <= 1'b0;
    end else begin
      rd_prev_q   <= rd_prev_d;
      wr_prev_q   <= wr_prev_d;
      hold_q      <= hold_d;
      rd_armed_q  <= rd_armed_d;
      wr_armed_q  <= wr_armed_d;
      rd_commit_q <= rd_commit_d;
      wr_commit_q <= wr_commit_d;
      rd_off_q    <= rd_off_d;
      wr_off_q    <= wr_off_d;
      wr_data_q   <= wr_data_d;
      wr_lanes_q  <= wr_lanes_d;
      ovf_q       <= ovf_d;
    end
  end

`ifdef IO_MAILBOX_IRQ_EN
  logic [1:0] ctrl_q, ctrl_d;
  logic       irq_q, irq_d;

  always_comb begin
    ctrl_d = ctrl_q;
    if (wr_commit_q && (wr_off_q == RegCtrl) && wr_lanes_q[0]) begin
      ctrl_d = wr_data_q[1:0];
    end
    irq_d = (ctrl_q[CtrlRxIrqEn] && !rx_empty) || (ctrl_q[CtrlTxIrqEn] && tx_empty);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ctrl_q <= '0;
      irq_q  <= 1'b0;
    end else begin
      ctrl_q <= ctrl_d;
      irq_q  <= irq_d;
    end
  end

  assign ctrl_rd = {14'h0, ctrl_q};
  assign irq     = irq_q;
`else
  assign ctrl_rd = 16'h0000;
  assign irq     = 1'b0;
`endif

  always_comb begin
    rd_word = '0;
    unique case (cur_off)
      RegData:   rd_word = rx_empty ? 16'h0000 : rx_head;
      RegStatus: begin
        rd_word[StRxNonempty] = !rx_empty;
        rd_word[StRxFull]     = rx_full;
        rd_word[StTxEmpty]    = tx_empty;
        rd_word[StTxFull]     = tx_full;
        rd_word[StTxOverflow] = ovf_q;
      end
      RegCtrl:   rd_word = ctrl_rd;
      RegCount:  rd_word = {8'(tx_cnt), 8'(rx_cnt)};
      default:   rd_word = '0;
    endcase
  end

  assign rd_drive   = !reset && sel && !memNotRead && memNotWrite;
  assign data[15:8] = (rd_drive && !csh_n) ? rd_word[15:8] : 8'hzz;
  assign data[7:0]  = (rd_drive && !csl_n) ? rd_word[7:0] : 8'hzz;

  assign rx_ready = !rx_full;
  assign tx_valid = !tx_empty;

  io_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (16)
  ) u_rx_fifo (
    .clock (clock),
    .reset (reset),
    .push  (rx_push),
    .pop   (rx_pop),
    .wdata (rx_data),
    .rdata (rx_head),
    .full  (rx_full),
    .empty (rx_empty),
    .count (rx_cnt)
  );

  io_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (16)
  ) u_tx_fifo (
    .clock (clock),
    .reset (reset),
    .push  (tx_push),
    .pop   (tx_pop),
    .wdata (wr_word),
    .rdata (tx_data),
    .full  (tx_full),
    .empty (tx_empty),
    .count (tx_cnt)
  );

endmodule

// File: tb/tb_io_mailbox.sv
// tb_io_mailbox: self-checking bench for io_mailbox with a queue-based reference model.
// The data bus is a tri1 net, so undriven lanes read back as 8'hFF.
module tb_io_mailbox;

  localparam int unsigned DEPTH = 8;
  localparam logic [14:0] BASE  = 15'h7FF0;
  localparam logic [1:0] ODATA = 2'd0, OSTAT = 2'd1, OCTRL = 2'd2, OCNT = 2'd3;

  logic        clock = 1'b0;
  logic        reset;
  logic [14:0] address;
  tri1  [15:0] data;
  logic        memNotRead, memNotWrite, csh_n, csl_n, select_dev;
  logic [15:0] rx_data;
  logic        rx_valid, rx_ready;
  logic [15:0] tx_data;
  logic        tx_valid, tx_ready, irq;
  logic        tb_oe;
  logic [15:0] tb_wdata;

  int total = 0;
  int bad   = 0;
  int acc_cnt = 0;

  // Reference model state
  logic [15:0] rxq[$];
  logic [15:0] txq[$];
  logic        ovf_m;
  logic [1:0]  ctrl_m;

  assign data = tb_oe ? tb_wdata : 16'hzzzz;
  always #5 clock = ~clock;
  always @(posedge clock) if (rx_valid && rx_ready) acc_cnt <= acc_cnt + 1;

  io_mailbox #(
    .BASE_ADDR  (BASE),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .address     (address),
    .data        (data),
    .memNotRead  (memNotRead),
    .memNotWrite (memNotWrite),
    .csh_n       (csh_n),
    .csl_n       (csl_n),
    .select_dev  (select_dev),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .irq         (irq)
  );

  // ---------------- reference model ----------------
  function automatic void model_reset();
    rxq.delete();
    txq.delete();
    ovf_m  = 1'b0;
    ctrl_m = 2'b00;
  endfunction

  function automatic logic [15:0] model_reg(input logic [1:0] off);
    logic [15:0] r = '0;
    case (off)
      ODATA: r = (rxq.size() != 0) ? rxq[0] : 16'h0000;
      OSTAT: begin
        r[0] = rxq.size() != 0;
        r[1] = rxq.size() == DEPTH;
        r[2] = txq.size() == 0;
        r[3] = txq.size() == DEPTH;
        r[4] = ovf_m;
      end
      OCTRL: r = {14'h0, ctrl_m};
      default: r = {8'(txq.size()), 8'(rxq.size())};
    endcase
    return r;
  endfunction

  function automatic void model_read(input logic [1:0] off);
    if (off == ODATA && rxq.size() != 0) void'(rxq.pop_front());
  endfunction

  function automatic void model_write(input logic [1:0] off, input logic [15:0] v,
                                      input logic hi, input logic lo);
    case (off)
      ODATA: begin
        if (txq.size() == DEPTH) ovf_m = 1'b1;
        else txq.push_back({(hi ? v[15:8] : 8'h00), (lo ? v[7:0] : 8'h00)});
      end
      OSTAT: if (lo && v[4]) ovf_m = 1'b0;
`ifdef IO_MAILBOX_IRQ_EN
      OCTRL: if (lo) ctrl_m = v[1:0];
`endif
      default: ;
    endcase
  endfunction

  function automatic logic model_irq();
`ifdef IO_MAILBOX_IRQ_EN
    return (ctrl_m[0] && rxq.size() != 0) || (ctrl_m[1] && txq.size() == 0);
`else
    return 1'b0;
`endif
  endfunction

  // Bus value expected on the tri1 net: unselected lanes float high.
  function automatic logic [15:0] on_bus(input logic [15:0] v, input logic hi, input logic lo);
    return {(hi ? v[15:8] : 8'hFF), (lo ? v[7:0] : 8'hFF)};
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic bus_idle();
    address     = '0;
    select_dev  = 1'b0;
    csh_n       = 1'b1;
    csl_n       = 1'b1;
    memNotRead  = 1'b1;
    memNotWrite = 1'b1;
    tb_oe       = 1'b0;
  endtask

  task automatic cpu_write(input logic [1:0] off, input logic [15:0] v, input logic hi,
                           input logic lo);
    @(posedge clock); #1;
    address = {BASE[14:2], off}; select_dev = 1'b1; csh_n = !hi; csl_n = !lo;
    tb_wdata = v; tb_oe = 1'b1; memNotWrite = 1'b0;
    repeat (2) @(posedge clock);
    #1 memNotWrite = 1'b1;
    @(posedge clock); #1 bus_idle();
    repeat (3) @(posedge clock);
    model_write(off, v, hi, lo);
  endtask

  task automatic cpu_read(input logic [1:0] off, input logic hi, input logic lo, input int hold,
                          output logic [15:0] rd, output bit stable);
    logic [15:0] s;
    @(posedge clock); #1;
    address = {BASE[14:2], off}; select_dev = 1'b1; csh_n = !hi; csl_n = !lo;
    memNotRead = 1'b0;
    stable = 1'b1;
    @(negedge clock); rd = data;
    for (int i = 1; i < hold; i++) begin
      @(negedge clock); s = data;
      if (s !== rd) stable = 1'b0;
    end
    @(posedge clock); #1 memNotRead = 1'b1;
    @(posedge clock); #1 bus_idle();
    repeat (3) @(posedge clock);
  endtask

  task automatic rx_push(input logic [15:0] w);
    @(posedge clock); #1;
    rx_data = w; rx_valid = 1'b1;
    @(posedge clock); #1 rx_valid = 1'b0;
    if (rxq.size() < DEPTH) rxq.push_back(w);
  endtask

  task automatic tx_pop_one();
    @(posedge clock); #1 tx_ready = 1'b1;
    @(posedge clock); #1 tx_ready = 1'b0;
    if (txq.size() != 0) void'(txq.pop_front());
  endtask

  task automatic do_reset();
    bus_idle();
    rx_valid = 1'b0; tx_ready = 1'b0; rx_data = '0; tb_wdata = '0;
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    model_reset();
    repeat (2) @(posedge clock);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [15:0] rd, e;
    bit st;
    do_reset();
    @(negedge clock);
    total++; if (rx_ready !== 1'b1) begin bad++; $display("FAIL reset_rx_ready got=%b want=1", rx_ready); end
    total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL reset_tx_valid got=%b want=0", tx_valid); end
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL reset_irq got=%b want=0", irq); end
    total++; if (data !== 16'hFFFF) begin bad++; $display("FAIL reset_bus_idle got=%h want=ffff", data); end
    // Memory-space read must not be answered.
    #1 address = {BASE[14:2], OSTAT}; csh_n = 1'b0; csl_n = 1'b0; memNotRead = 1'b0;
    @(negedge clock);
    total++; if (data !== 16'hFFFF) begin bad++; $display("FAIL mem_space_read got=%h want=ffff", data); end
    #1 bus_idle();
    for (int o = 1; o < 4; o++) begin
      e = model_reg(2'(o));
      cpu_read(2'(o), 1'b1, 1'b1, 1, rd, st);
      total++; if (rd !== e) begin bad++; $display("FAIL reset_reg%0d got=%h want=%h", o, rd, e); end
    end
  endtask

  task automatic test_rx_read();
    logic [15:0] rd, e;
    bit st;
    rx_push(16'hA5A5);
    rx_push(16'h1234);
    for (int i = 0; i < 2; i++) begin
      e = model_reg(OCNT);
      cpu_read(OCNT, 1'b1, 1'b1, 1, rd, st);
      total++; if (rd !== e) begin bad++; $display("FAIL rx_count%0d got=%h want=%h", i, rd, e); end
      e = model_reg(ODATA);
      cpu_read(ODATA, 1'b1, 1'b1, 1, rd, st);
      model_read(ODATA);
      total++; if (rd !== e) begin bad++; $display("FAIL rx_data%0d got=%h want=%h", i, rd, e); end
    end
    e = model_reg(OSTAT);
    cpu_read(OSTAT, 1'b1, 1'b1, 1, rd, st);
    total++; if (rd !== e) begin bad++; $display("FAIL rx_status_end got=%h want=%h", rd, e); end
    // Empty read returns zero without disturbing state.
    cpu_read(ODATA, 1'b1, 1'b1, 1, rd, st);
    total++; if (rd !== 16'h0000) begin bad++; $display("FAIL rx_empty_read got=%h want=0000", rd); end
    cpu_read(OCNT, 1'b1, 1'b1, 1, rd, st);
    total++; if (rd !== 16'h0000) begin bad++; $display("FAIL rx_empty_count got=%h want=0000", rd); end
  endtask

  task automatic test_tx_overflow();
    logic [15:0] rd, e;
    bit st;
    for (int i = 0; i <= DEPTH; i++) cpu_write(ODATA, 16'h1000 + 16'(i), 1'b1, 1'b1);
    e = model_reg(OCNT);
    cpu_read(OCNT, 1'b1, 1'b1, 1, rd, st);
    total++; if (rd !== e) begin bad++; $display("FAIL ovf_count got=%h want=%h", rd, e); end
    e = model_reg(OSTAT);
    cpu_read(OSTAT, 1'b1, 1'b1, 1, rd, st);
    total++; if (rd !== e) begin bad++; $display("FAIL ovf_status got=%h want=%h", rd, e); end
    cpu_write(OSTAT, 16'h0010, 1'b1, 1'b1);
    e = model_reg(OSTAT);
    cpu_read(OSTAT, 1'b1, 1'b1, 1, rd, st);
    total++; if (rd !== e) begin bad++; $display("FAIL ovf_clear got=%h want=%h", rd, e); end
    while (txq.size() != 0) begin
      @(negedge clock);
      total++;
      if (tx_valid !== 1'b1 || tx_data !== txq[0]) begin
        bad++; $display("FAIL tx_drain got=%b/%h want=1/%h", tx_valid, tx_data, txq[0]);
      end
      tx_pop_one();
    end
    @(negedge clock);
    total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL tx_drained got=%b want=0", tx_valid); end
  endtask

  task automatic test_byte_lanes();
    logic [15:0] rd, e;
    bit st;
    cpu_write(ODATA, 16'hBEEF, 1'b0, 1'b1);
    @(negedge clock);
    total++; if (tx_data !== txq[0]) begin bad++; $display("FAIL byte_write got=%h want=%h", tx_data, txq[0]); end
    tx_pop_one();
    rx_push(16'h1234);
    e = on_bus(model_reg(ODATA), 1'b1, 1'b0);
    cpu_read(ODATA, 1'b1, 1'b0, 1, rd, st);
    model_read(ODATA);
    total++; if (rd !== e) begin bad++; $display("FAIL byte_read got=%h want=%h", rd, e); end
    e = model_reg(OCNT);
    cpu_read(OCNT, 1'b0, 1'b1, 1, rd, st);
    total++; if (rd[7:0] !== e[7:0]) begin bad++; $display("FAIL byte_pop got=%h want=%h", rd[7:0], e[7:0]); end
  endtask

  task automatic test_long_read();
    logic [15:0] rd, e;
    bit st;
    rx_push(16'($urandom));
    rx_push(16'($urandom));
    e = model_reg(ODATA);
    cpu_read(ODATA, 1'b1, 1'b1, 5, rd, st);
    model_read(ODATA);
    total++; if (rd !== e) begin bad++; $display("FAIL long_read got=%h want=%h", rd, e); end
    total++; if (st !== 1'b1) begin bad++; $display("FAIL long_stable got=%b want=1", st); end
    e = model_reg(OCNT);
    cpu_read(OCNT, 1'b1, 1'b1, 1, rd, st);
    total++; if (rd !== e) begin bad++; $display("FAIL long_one_pop got=%h want=%h", rd, e); end
    e = model_reg(ODATA);
    cpu_read(ODATA, 1'b1, 1'b1, 1, rd, st);
    model_read(ODATA);
    total++; if (rd !== e) begin bad++; $display("FAIL long_second got=%h want=%h", rd, e); end
  endtask

  task automatic test_rx_full_pop();
    logic [15:0] rd, e, w;
    int base;
    bit st;
    for (int i = 0; i < DEPTH; i++) rx_push(16'($urandom));
    w = 16'($urandom);
    @(negedge clock);
    total++; if (rx_ready !== 1'b0) begin bad++; $display("FAIL full_ready got=%b want=0", rx_ready); end
    base = acc_cnt;
    #1 rx_data = w; rx_valid = 1'b1;
    e = model_reg(ODATA);
    cpu_read(ODATA, 1'b1, 1'b1, 1, rd, st);
    model_read(ODATA);
    rxq.push_back(w);
    @(negedge clock);
    total++; if (rd !== e) begin bad++; $display("FAIL full_pop_data got=%h want=%h", rd, e); end
    total++; if (acc_cnt - base !== 1) begin bad++; $display("FAIL full_accepts got=%0d want=1", acc_cnt - base); end
    total++; if (rx_ready !== 1'b0) begin bad++; $display("FAIL refull_ready got=%b want=0", rx_ready); end
    #1 rx_valid = 1'b0;
    e = model_reg(OCNT);
    cpu_read(OCNT, 1'b1, 1'b1, 1, rd, st);
    total++; if (rd !== e) begin bad++; $display("FAIL refull_count got=%h want=%h", rd, e); end
    while (rxq.size() != 0) begin
      e = model_reg(ODATA);
      cpu_read(ODATA, 1'b1, 1'b1, 1, rd, st);
      model_read(ODATA);
      total++; if (rd !== e) begin bad++; $display("FAIL full_drain got=%h want=%h", rd, e); end
    end
  endtask

  task automatic test_reset_mid_write();
    logic [15:0] rd, e;
    bit st;
    @(posedge clock); #1;
    address = {BASE[14:2], ODATA}; select_dev = 1'b1; csh_n = 1'b0; csl_n = 1'b0;
    tb_wdata = 16'h5555; tb_oe = 1'b1; memNotWrite = 1'b0;
    @(posedge clock); #1 reset = 1'b1;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    model_reset();
    repeat (2) @(posedge clock);
    #1 memNotWrite = 1'b1;
    @(posedge clock); #1 bus_idle();
    repeat (4) @(posedge clock);
    @(negedge clock);
    total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL midreset_tx_valid got=%b want=0", tx_valid); end
    e = model_reg(OCNT);
    cpu_read(OCNT, 1'b1, 1'b1, 1, rd, st);
    total++; if (rd !== e) begin bad++; $display("FAIL midreset_count got=%h want=%h", rd, e); end
  endtask

  task automatic test_irq();
    logic [15:0] rd, e;
    bit st;
    cpu_write(OCTRL, 16'h0001, 1'b0, 1'b1);
    e = model_reg(OCTRL);
    cpu_read(OCTRL, 1'b1, 1'b1, 1, rd, st);
    total++; if (rd !== e) begin bad++; $display("FAIL ctrl_read got=%h want=%h", rd, e); end
    @(negedge clock);
    total++; if (irq !== model_irq()) begin bad++; $display("FAIL irq_idle got=%b want=%b", irq, model_irq()); end
    @(posedge clock); #1 rx_data = 16'h00AA; rx_valid = 1'b1;
    @(posedge clock); #1 rx_valid = 1'b0;
    @(negedge clock);
    // Registered irq still reflects the pre-push state here.
    total++; if (irq !== model_irq()) begin bad++; $display("FAIL irq_latency got=%b want=%b", irq, model_irq()); end
    rxq.push_back(16'h00AA);
    @(negedge clock);
    total++; if (irq !== model_irq()) begin bad++; $display("FAIL irq_rx got=%b want=%b", irq, model_irq()); end
    cpu_write(OCTRL, 16'h0002, 1'b0, 1'b1);
    cpu_read(ODATA, 1'b1, 1'b1, 1, rd, st);
    model_read(ODATA);
    @(negedge clock);
    total++; if (irq !== model_irq()) begin bad++; $display("FAIL irq_tx got=%b want=%b", irq, model_irq()); end
    cpu_write(OCTRL, 16'h0000, 1'b0, 1'b1);
    @(negedge clock);
    total++; if (irq !== model_irq()) begin bad++; $display("FAIL irq_off got=%b want=%b", irq, model_irq()); end
  endtask

  task automatic test_random();
    logic [15:0] rd, e, v;
    logic [1:0] ln;
    bit st;
    for (int n = 0; n < 80; n++) begin
      case ($urandom_range(0, 5))
        0: rx_push(16'($urandom));
        1: begin
          @(negedge clock);
          total++;
          if (txq.size() == 0) begin
            if (tx_valid !== 1'b0) begin bad++; $display("FAIL rnd_tx_valid got=%b want=0", tx_valid); end
          end else if (tx_valid !== 1'b1 || tx_data !== txq[0]) begin
            bad++; $display("FAIL rnd_tx_head got=%b/%h want=1/%h", tx_valid, tx_data, txq[0]);
          end
          tx_pop_one();
        end
        2: begin
          v  = 16'($urandom);
          ln = 2'($urandom_range(1, 3));
          cpu_write(ODATA, v, ln[1], ln[0]);
        end
        3: begin
          e = model_reg(ODATA);
          cpu_read(ODATA, 1'b1, 1'b1, 1, rd, st);
          model_read(ODATA);
          total++; if (rd !== e) begin bad++; $display("FAIL rnd_data got=%h want=%h", rd, e); end
        end
        4: begin
          e = model_reg(OCNT);
          cpu_read(OCNT, 1'b1, 1'b1, 1, rd, st);
          total++; if (rd !== e) begin bad++; $display("FAIL rnd_count got=%h want=%h", rd, e); end
        end
        default: begin
          e = model_reg(OSTAT);
          cpu_read(OSTAT, 1'b1, 1'b1, 1, rd, st);
          total++; if (rd !== e) begin bad++; $display("FAIL rnd_status got=%h want=%h", rd, e); end
          if ($urandom_range(0, 1) == 1) cpu_write(OSTAT, 16'h0010, 1'b0, 1'b1);
        end
      endcase
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    test_reset();
    test_rx_read();
    test_tx_overflow();
    test_byte_lanes();
    test_long_read();
    test_rx_full_pop();
    test_reset_mid_write();
    test_irq();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
